// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, taken-branch
// and data-memory-wait hazards, and keeps stall/flush counters plus a sticky timeout flag.
module hazard_controller #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D_i,
    input  logic [4:0]  Rs2D_i,
    input  logic [4:0]  RdE_i,
    input  logic        LoadE_i,
    input  logic        PCSrcE_i,
    input  logic        MemReqM_i,
    input  logic        MemReadyM_i,
    output logic        StallF_o,
    output logic        StallD_o,
    output logic        StallE_o,
    output logic        StallM_o,
    output logic        FlushD_o,
    output logic        FlushE_o,
    output logic        MemTimeout_o,
    output logic [31:0] StallCount_o,
    output logic [31:0] FlushCount_o
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        LOAD_STALL
    } state_t;

    localparam logic [2:0]  BUBBLE_INIT   = 3'(LOAD_USE_STALLS - 1);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

    state_t      state, state_next;
    logic [2:0]  bubble_cnt, bubble_next;
    logic [15:0] wait_cnt, wait_next;
    logic        mem_timeout;
    logic [31:0] stall_count, flush_count;

    logic load_use_hit;
    logic mem_block;
    logic timeout_hit;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

    assign load_use_hit = LoadE_i && (RdE_i != 5'd0) &&
                          ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

    // Once waiting, only the ready strobe matters; elsewhere a request must be outstanding.
    assign mem_block = (state == MEM_WAIT) ? !MemReadyM_i : (MemReqM_i && !MemReadyM_i);

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        state_next  = state;
        bubble_next = bubble_cnt;

        if (mem_block) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            if (state == RUN) begin
                state_next = MEM_WAIT;
            end
        end else if (state == LOAD_STALL) begin
            stall_f     = 1'b1;
            stall_d     = 1'b1;
            flush_e     = 1'b1;
            bubble_next = bubble_cnt - 3'd1;
            if (bubble_cnt == 3'd1) begin
                state_next = RUN;
            end
        end else begin
            // RUN, or the ready cycle of MEM_WAIT: a held branch is flushed here too.
            state_next = RUN;
            if (PCSrcE_i) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use_hit) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                if (LOAD_USE_STALLS > 1) begin
                    state_next  = LOAD_STALL;
                    bubble_next = BUBBLE_INIT;
                end
            end
        end
    end

    always_comb begin
        wait_next = 16'd0;
        if (mem_block) begin
            wait_next = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = mem_block && (wait_next == TIMEOUT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            bubble_cnt  <= 3'd0;
            wait_cnt    <= 16'd0;
            mem_timeout <= 1'b0;
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            state      <= state_next;
            bubble_cnt <= bubble_next;
            wait_cnt   <= wait_next;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            if (stall_f) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush_d) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    // Reset forces a bubble into D and E regardless of the hazard inputs.
    assign StallF_o     = rst_n && stall_f;
    assign StallD_o     = rst_n && stall_d;
    assign StallE_o     = rst_n && stall_e;
    assign StallM_o     = rst_n && stall_m;
    assign FlushD_o     = !rst_n || flush_d;
    assign FlushE_o     = !rst_n || flush_e;
    assign MemTimeout_o = mem_timeout;
    assign StallCount_o = stall_count;
    assign FlushCount_o = flush_count;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable (stall) and clear (flush) controls of the fetch/decode, decode/execute and execute/memory pipeline registers. It resolves three hazards: load-use data hazards, taken-branch redirects, and multi-cycle data-memory waits. It also keeps per-hazard performance counters and a sticky memory-timeout flag.

Parameters:
LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 255, consecutive memory-wait cycles after which MemTimeout_o sets (1..65535)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
Rs1D_i  input  5  rs1 index of the instruction in decode
Rs2D_i  input  5  rs2 index of the instruction in decode
RdE_i  input  5  rd index of the instruction in execute
LoadE_i  input  1  instruction in execute is a load
PCSrcE_i  input  1  taken branch/jump resolved in execute
MemReqM_i  input  1  memory stage has an active data-memory access
MemReadyM_i  input  1  data memory completes the access this cycle
StallF_o  output  1  hold the PC register
StallD_o  output  1  hold the fetch/decode register
StallE_o  output  1  hold the decode/execute register
StallM_o  output  1  hold the execute/memory register
FlushD_o  output  1  clear the fetch/decode register (insert NOP)
FlushE_o  output  1  clear the decode/execute register (insert NOP)
MemTimeout_o  output  1  sticky: a memory wait reached MEM_TIMEOUT
StallCount_o  output  32  cycles with StallF_o=1, wraps at 2^32
FlushCount_o  output  32  cycles with a branch flush, wraps at 2^32

Behaviour:
- Stall/flush outputs are combinational from the current state and inputs, so they act in the same cycle. State and counters are registered.
- While rst_n=0:
  - Stall outputs are 0; FlushD_o and FlushE_o are 1.
  - State is RUN, all counters are 0, MemTimeout_o is 0.
  - Reset mid-wait or mid-stall abandons the operation immediately.
- load-use hit = LoadE_i and RdE_i!=0 and (RdE_i==Rs1D_i or RdE_i==Rs2D_i).
- State RUN, outputs by priority:
  1. MemReqM_i and !MemReadyM_i: assert StallF/StallD/StallE/StallM, no flushes. Next state MEM_WAIT; wait counter starts at 1.
  2. Else PCSrcE_i: assert FlushD and FlushE, no stalls. Branch wins over a simultaneous load-use hit because the decode instruction is wrong-path.
  3. Else load-use hit: assert StallF, StallD and FlushE.
     - If LOAD_USE_STALLS>1: next state LOAD_STALL, bubble counter = LOAD_USE_STALLS-1.
  4. Else all outputs 0.
- State MEM_WAIT:
  - If !MemReadyM_i: assert all four stalls and increment the wait counter. When the counter equals MEM_TIMEOUT, set MemTimeout_o; it stays set until reset. Stalling continues regardless.
  - If MemReadyM_i: outputs are computed exactly as in RUN with the memory term false. Next state RUN. A branch held in execute during the wait is therefore flushed in this cycle.
- State LOAD_STALL:
  - Assert StallF, StallD and FlushE; decrement the bubble counter; go to RUN when it reaches 0.
  - MemReqM_i and !MemReadyM_i overrides: assert all four stalls. The bubble counter holds and the state is unchanged until memory is ready.
  - PCSrcE_i cannot occur here, because execute holds a bubble.
- Counters, updated at posedge:
  - StallCount increments when StallF_o=1.
  - FlushCount increments when FlushD_o=1 and rst_n=1.
  - The wait counter is 16-bit and saturates.

Test Plan:
- Load-use: LoadE_i=1, RdE_i=5, Rs1D_i=5, default parameters -> exactly 1 cycle of StallF/StallD/FlushE=1, then all 0; StallCount_o=1.
- LOAD_USE_STALLS=3 with the same stimulus -> 3 consecutive bubble cycles, then RUN; StallCount_o=3. Repeat with RdE_i=0 -> no stall.
- Branch plus load-use in the same cycle: PCSrcE_i=1 and a load-use hit on Rs2D_i -> FlushD/FlushE=1, StallF=0; FlushCount_o=1.
- Memory wait: MemReqM_i=1, MemReadyM_i low for 4 cycles with PCSrcE_i=1 held -> 4 cycles of all stalls; the ready cycle flushes D and E; MemTimeout_o stays 0.
- Timeout: MEM_TIMEOUT=8, MemReadyM_i low for 10 cycles -> MemTimeout_o rises after the 8th wait cycle and stays 1 after ready returns.
- Reset: drop rst_n in the second cycle of MEM_WAIT -> stalls 0 and flushes 1 immediately; counters 0; after release, state is RUN.
